// File: rtl/fp_pkg.sv
// Shared constants and types for the float-to-integer converter.
package fp_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Legacy state encodings, kept so existing waveform decoders still match
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_FIN   = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_FIN   = S_FIN,
        ST_DONE  = S_DONE
    } state_t;

    // Result class decided at unpack time; only CLS_NORM uses the shifter
    typedef enum logic [2:0] {
        CLS_NORM    = 3'd0,
        CLS_ZERO    = 3'd1,
        CLS_POS_SAT = 3'd2,
        CLS_NEG_SAT = 3'd3,
        CLS_NEG_MIN = 3'd4,
        CLS_NAN     = 3'd5
    } cls_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of an IEEE-754 single: sign, mantissa, result class,
// shift direction and shift count for the serial aligner.
// FP_TO_INT_RNE_EN lowers the smallest converted exponent to -1 so that
// values in [0.5, 1) can round up.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] in_float,
    output logic        sign,
    output logic [23:0] mant,
    output cls_t        cls,
    output logic        shift_left,
    output logic [4:0]  shift_n
);

`ifdef FP_TO_INT_RNE_EN
    localparam int E_MIN = -1;
`else
    localparam int E_MIN = 0;
`endif

    localparam logic [7:0] EXP_MIN  = 8'(FP_BIAS + E_MIN);
    localparam logic [7:0] EXP_LEFT = 8'(FP_BIAS + 23);
    localparam logic [7:0] EXP_SAT  = 8'(FP_BIAS + 31);
    localparam logic [7:0] EXP_SPEC = 8'(FP_EXP_MAX);

    fp_unpacked_t uf;
    logic         frac_nz;

    // Field split, then classify by biased exponent range
    always_comb begin
        uf.sign    = in_float[31];
        uf.exp     = in_float[30:23];
        uf.mant    = (uf.exp != 8'd0) ? {1'b1, in_float[22:0]} : '0;
        frac_nz    = |in_float[22:0];
        cls        = CLS_NORM;
        shift_left = 1'b0;
        shift_n    = '0;
        if (uf.exp == EXP_SPEC) begin
            if (frac_nz)
                cls = CLS_NAN;
            else
                cls = uf.sign ? CLS_NEG_SAT : CLS_POS_SAT;
        end else if (uf.exp >= EXP_SAT) begin
            if (!uf.sign)
                cls = CLS_POS_SAT;
            else if (uf.exp == EXP_SAT && !frac_nz)
                cls = CLS_NEG_MIN;
            else
                cls = CLS_NEG_SAT;
        end else if (uf.exp < EXP_MIN) begin
            cls = CLS_ZERO;
        end else if (uf.exp >= EXP_LEFT) begin
            shift_left = 1'b1;
            shift_n    = 5'(uf.exp - EXP_LEFT);
        end else begin
            shift_n    = 5'(EXP_LEFT - uf.exp);
        end
        sign = uf.sign;
        mant = uf.mant;
    end

endmodule

// File: rtl/fp_to_int.sv
// Sequential IEEE-754 single to signed 32-bit integer converter.
// Alignment is one bit per cycle; valid/ready on both sides, one value in flight.
// Build option: FP_TO_INT_RNE_EN selects round-to-nearest-even (default truncates).
module fp_to_int
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        ovf
);

    logic        u_sign;
    logic [23:0] u_mant;
    cls_t        u_cls;
    logic        u_left;
    logic [4:0]  u_n;

    state_t      state;
    logic [31:0] mag;
    logic [4:0]  cnt;
    logic        dir_left;
    logic        sign_q;
    cls_t        cls_q;
    logic [31:0] rnd;
    logic [31:0] fin_int;
    logic        fin_ovf;

`ifdef FP_TO_INT_RNE_EN
    logic        guard;
    logic        sticky;
`endif

    fp_unpack u_unpack (
        .in_float   (in_float),
        .sign       (u_sign),
        .mant       (u_mant),
        .cls        (u_cls),
        .shift_left (u_left),
        .shift_n    (u_n)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Result for the FIN step: rounding, sign application, special values
    always_comb begin
`ifdef FP_TO_INT_RNE_EN
        rnd = mag + {31'd0, guard & (sticky | mag[0])};
`else
        rnd = mag;
`endif
        fin_int = '0;
        fin_ovf = 1'b0;
        case (cls_q)
            CLS_NAN, CLS_POS_SAT: begin
                fin_int = INT_MAX;
                fin_ovf = 1'b1;
            end
            CLS_NEG_SAT: begin
                fin_int = INT_MIN;
                fin_ovf = 1'b1;
            end
            CLS_NEG_MIN: fin_int = INT_MIN;
            CLS_ZERO:    fin_int = '0;
            default:     fin_int = sign_q ? (~rnd + 32'd1) : rnd;
        endcase
    end

    // Control FSM plus the serial aligner and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mag      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
            sign_q   <= 1'b0;
            cls_q    <= CLS_ZERO;
            out_int  <= '0;
            ovf      <= 1'b0;
`ifdef FP_TO_INT_RNE_EN
            guard    <= 1'b0;
            sticky   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mag      <= {8'd0, u_mant};
                        cnt      <= u_n;
                        dir_left <= u_left;
                        sign_q   <= u_sign;
                        cls_q    <= u_cls;
`ifdef FP_TO_INT_RNE_EN
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
`endif
                        state    <= (u_n != 5'd0) ? ST_SHIFT : ST_FIN;
                    end
                end
                ST_SHIFT: begin
                    if (dir_left) begin
                        mag <= mag << 1;
                    end else begin
                        mag    <= mag >> 1;
`ifdef FP_TO_INT_RNE_EN
                        guard  <= mag[0];
                        sticky <= sticky | guard;
`endif
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    out_int <= fin_int;
                    ovf     <= fin_ovf;
                    state   <= ST_DONE;
                end
                default: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: a driver pushes expected results computed
// from real-valued arithmetic; a monitor pops and compares on each transfer.
module tb_fp_to_int;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_float  = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_int;
    logic        ovf;

`ifdef FP_TO_INT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct {
        logic [31:0] fin;
        logic [31:0] val;
        logic        ovf;
        int          lat;
        int          acc;
        bit          hold;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    fp_to_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_float  (in_float),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else        for (int i = 0; i < -k; i++) p = p / 2.0;
        return p;
    endfunction

    // Reference: take the float's real value and round it as an integer would be
    function automatic void model(input logic [31:0] f, output logic [31:0] v,
                                  output logic o, output int lat);
        int     ex;
        int     fr;
        int     e;
        bit     s;
        real    a;
        real    fl;
        real    d;
        longint m;
        ex = int'(f[30:23]);
        fr = int'(f[22:0]);
        s  = f[31];
        e  = ex - 127;
        if (ex == 255 || ex == 0 || e >= 31 || e < (RNE ? -1 : 0))
            lat = 1;
        else
            lat = ((e >= 23) ? (e - 23) : (23 - e)) + 1;
        o = 1'b0;
        if (ex == 255 && fr != 0) begin
            v = 32'h7FFF_FFFF;
            o = 1'b1;
            return;
        end
        if (ex == 255)      a = 1.0e40;
        else if (ex == 0)   a = real'(fr) * pow2(-149);
        else                a = real'(fr + 8388608) * pow2(ex - 150);
        if (!s && a >= 2147483648.0) begin
            v = 32'h7FFF_FFFF;
            o = 1'b1;
        end else if (s && a > 2147483648.0) begin
            v = 32'h8000_0000;
            o = 1'b1;
        end else if (s && a == 2147483648.0) begin
            v = 32'h8000_0000;
        end else begin
            fl = $floor(a);
            d  = a - fl;
            m  = longint'(fl);
            if (RNE && (d > 0.5 || (d == 0.5 && m[0]))) m = m + 1;
            if (s) m = -m;
            v = m[31:0];
        end
    endfunction

    task automatic convert(input logic [31:0] f, input bit hold, input bit noise);
        exp_t e;
        int   k;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready still %0b, expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_float = f;
        @(negedge clk);
        e.fin  = f;
        model(f, e.val, e.ovf, e.lat);
        e.acc  = cyc;
        e.hold = hold;
        sb.push_back(e);
        in_valid = 1'b0;
        chk("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
        k = 0;
        while (!in_ready && k < 300) begin
            in_valid = noise && ($urandom % 2 == 0);
            in_float = $urandom;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: in_ready still %0b, expected 1", in_ready);
        end
    endtask

    // Monitor: drives out_ready, checks latency, stability and result values
    initial begin : monitor
        int          hold_cnt;
        bit          pend;
        logic [31:0] h_int;
        logic        h_ovf;
        exp_t        e;
        hold_cnt = 0;
        pend     = 1'b0;
        h_int    = '0;
        h_ovf    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend      = 1'b0;
                hold_cnt  = 0;
                out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!pend) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: out_int %0h with no conversion pending", out_int);
                    end else begin
                        chk($sformatf("latency_%08h", sb[0].fin),
                            64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        hold_cnt = sb[0].hold ? 10 : 0;
                    end
                    h_int = out_int;
                    h_ovf = ovf;
                end else begin
                    chk("stall_out_int_stable", {32'd0, out_int}, {32'd0, h_int});
                    chk("stall_ovf_stable", {63'd0, ovf}, {63'd0, h_ovf});
                end
                chk("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
            end
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else begin
                out_ready = ($urandom % 4) != 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("out_int_%08h", e.fin), {32'd0, out_int}, {32'd0, e.val});
                    chk($sformatf("ovf_%08h", e.fin), {63'd0, ovf}, {63'd0, e.ovf});
                end
                pend = 1'b0;
            end else begin
                pend = out_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] directed [0:18];
        logic [31:0] f;
        logic [7:0]  ex;
        logic [22:0] fr;
        int          r;
        directed = '{32'h3F80_0000, 32'h4060_0000, 32'hC020_0000, 32'h4E80_0000,
                     32'h3F00_0000, 32'h3F40_0000, 32'h4F00_0000, 32'hCF00_0000,
                     32'h7FC0_0000, 32'hFF80_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF,
                     32'h0000_0001, 32'h8000_0000, 32'h3F7F_FFFF, 32'hBF40_0000,
                     32'h3EFF_FFFF, 32'h7F80_0000, 32'hFFC0_0001};

        repeat (3) @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_int", {32'd0, out_int}, 64'd0);
        chk("reset_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++)
            convert(directed[i], (i == 1), 1'b1);

        // Reset during SHIFT of a 1.0 conversion (23 shifts); prior result is nonzero
        convert(32'h3F80_0000, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_float = 32'h3F80_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_op_in_ready_busy", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_int", {32'd0, out_int}, 64'd0);
        chk("mid_rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(32'h4060_0000, 1'b0, 1'b1);
        convert(32'hC020_0000, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom % 10);
            if (r < 7)       ex = 8'($urandom_range(120, 160));
            else if (r == 7) ex = 8'($urandom_range(0, 255));
            else if (r == 8) ex = ($urandom % 2 == 0) ? 8'd255 : 8'd0;
            else             ex = ($urandom % 2 == 0) ? 8'd158 : 8'd126;
            fr = 23'($urandom);
            if ($urandom % 4 == 0)
                fr = ($urandom % 2 == 0) ? 23'd0 : (fr & 23'h7F_0000) | 23'h00_8000;
            f = {1'($urandom), ex, fr};
            convert(f, ($urandom % 16 == 0), 1'b1);
        end

        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
